// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by hazard_ctrl and hazard_perf_cnt.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating 16-bit event counter with synchronous clear.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_d;
    logic [15:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and memory-wait freeze for the 5-stage core.
// Optional perf counters (stall_cnt, flush_cnt) under HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int REG_W       = hazard_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    import hazard_pkg::*;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    state_e        state_d, state_q;
    logic [CW-1:0] wcnt_d, wcnt_q;
    logic          br_pend_d, br_pend_q;
    logic          mem_err_d, mem_err_q;
    logic          load_use;

    assign load_use = idex_mem_read
                   && idex_rt != REG_W'(ZERO_REG)
                   && (idex_rt == ifid_rs
                       || (ifid_uses_rt && idex_rt == ifid_rt));

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        br_pend_d  = br_pend_q;
        mem_err_d  = (state_q == ERR);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            wcnt_d     = '0;
            br_pend_d  = 1'b0;
            mem_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                ERR: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_d    = RUN;
                        br_pend_d  = 1'b0;
                        ifid_flush = br_pend_q;
                        idex_flush = br_pend_q;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        pipe_hold  = 1'b1;
                        if (wcnt_q >= TMO) begin
                            state_d = ERR;
                        end else begin
                            wcnt_d = wcnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    // A branch seen on wait entry is replayed on exit.
                    if (mem_req && !mem_ready) begin
                        state_d    = MEM_WAIT;
                        wcnt_d     = CW'(1);
                        br_pend_d  = ex_branch_taken;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        pipe_hold  = 1'b1;
                    end else if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            br_pend_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            br_pend_q <= br_pend_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~pc_write),
        .cnt (stall_cnt)
    );

    hazard_perf_cnt u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ifid_flush),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; counter checks run when built
// with HAZARD_PERF_EN.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err}
    localparam logic [5:0] E_RST  = 6'b001100;
    localparam logic [5:0] E_RUN  = 6'b110000;
    localparam logic [5:0] E_STL  = 6'b000100;
    localparam logic [5:0] E_BR   = 6'b111100;
    localparam logic [5:0] E_HOLD = 6'b000010;
    localparam logic [5:0] E_ERR  = 6'b000011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_mem_read;
    logic       ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush;
    logic       idex_flush, pipe_hold, mem_err;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .REG_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .ifid_uses_rt    (ifid_uses_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pipe_hold       (pipe_hold),
        .mem_err         (mem_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    wire [5:0] outs = {pc_write, ifid_write, ifid_flush,
                       idex_flush, pipe_hold, mem_err};

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic lr,
                         input logic [4:0] lrt, input logic br,
                         input logic req, input logic rdy);
        ifid_rs         = rs;
        ifid_rt         = rt;
        ifid_uses_rt    = urt;
        idex_mem_read   = lr;
        idex_rt         = lrt;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expectation is queued with the stimulus, compared mid-cycle.
    task automatic cycle(input string tag, input logic [5:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(negedge clk);
        check_eq(tag_q.pop_front(), 32'(outs), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    task automatic perf(input string tag, input int s, input int f);
`ifdef HAZARD_PERF_EN
        check_eq({tag, "_stall"}, 32'(stall_cnt), 32'(s));
        check_eq({tag, "_flush"}, 32'(flush_cnt), 32'(f));
`else
        if (tag.len() < 0 || s < 0 || f < 0) begin
            $display("unexpected perf arguments");
        end
`endif
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("rst", E_RST);
        perf("rst", 0, 0);
        rst = 1'b0;
        cycle("post_rst", E_RUN);

        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs", E_STL);
        idle();
        cycle("lu_rs_after", E_RUN);
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cycle("lu_rt", E_STL);
        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cycle("lu_rt_unused", E_RUN);
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("lu_zero", E_RUN);
        drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        cycle("br_lu", E_BR);
        idle();
        perf("cnt1", 2, 1);
        cycle("br_after", E_RUN);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cycle("mw_entry", E_HOLD);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("mw_1", E_HOLD);
        cycle("mw_2", E_HOLD);
        mem_ready = 1'b1;
        cycle("mw_exit_flush", E_BR);
        idle();
        cycle("mw_after", E_RUN);
        perf("cnt2", 5, 2);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle("mem_fast", E_RUN);
        idle();
        cycle("mem_fast_after", E_RUN);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("to_entry", E_HOLD);
        for (int i = 0; i < TMO; i++) begin
            cycle($sformatf("to_wait%0d", i + 1), E_HOLD);
        end
        cycle("err_enter", E_HOLD);
        mem_ready = 1'b1;
        cycle("err_sticky", E_ERR);
        cycle("err_sticky2", E_ERR);
`ifdef HAZARD_PERF_EN
        repeat (70000) @(posedge clk);
        #1;
        perf("sat", 16'hFFFF, 2);
`endif

        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("rst_err", E_RST);
        perf("rst_err", 0, 0);
        rst = 1'b0;
        cycle("run_after_err", E_RUN);

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cycle("w_entry_br", E_HOLD);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("w_hold", E_HOLD);
        rst = 1'b1;
        cycle("rst_in_wait", E_RST);
        rst = 1'b0;
        idle();
        cycle("run_after_wrst", E_RUN);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("w2_entry", E_HOLD);
        mem_ready = 1'b1;
        cycle("w2_exit_no_pend", E_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. Sequences the PC, IF/ID and ID/EX pipeline registers: inserts one-cycle load-use bubbles, flushes wrong-path instructions on a taken branch resolved in EX, and freezes the pipeline while a multi-cycle data-memory access is outstanding. Sits beside the decode stage. Drives the write enables of PC and IF/ID, and the zero-control (bubble) select feeding the ID/EX register's control input.

## Interface
- MEM_TIMEOUT, 64: max cycles waiting on `mem_ready` before `mem_err` is raised; legal range 2..65535.
- REG_W, 5: register index width.

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ifid_rs  in  REG_W  rs field of the instruction in decode.
- ifid_rt  in  REG_W  rt field of the instruction in decode.
- ifid_uses_rt  in  1  decode instruction reads rt (R-type, store, branch).
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rt  in  REG_W  load destination register in ID/EX.
- ex_branch_taken  in  1  branch in EX resolved taken (beq or bne).
- mem_req  in  1  MEM stage is issuing a data access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX control field loads all-zero (bubble).
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- mem_err  out  1  sticky; the access timed out.
- stall_cnt, flush_cnt  out  16 each  present only with HAZARD_PERF_EN.

## Operation
- FSM states are RUN, MEM_WAIT and ERR. Reset enters RUN.
- Load-use hazard (RUN only): `idex_mem_read` is set, `idex_rt` ≠ 0, and `idex_rt` equals `ifid_rs`, or equals `ifid_rt` while `ifid_uses_rt` is set.
  - Response: pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle.
- Taken branch (RUN): ifid_flush=1 and idex_flush=1; pc_write=1, ifid_write=1.
- Branch taken in the same cycle as a load-use hazard: the branch wins. No stall; the PC loads the target.
- Transitions out of RUN:
  - `mem_req` set and `mem_ready` clear: go to MEM_WAIT and load the wait counter with 1.
  - `mem_req` and `mem_ready` both set in the same cycle: stay in RUN.
- MEM_WAIT outputs: pc_write=0, ifid_write=0, pipe_hold=1, no flushes. The counter increments each cycle.
- Exit from MEM_WAIT:
  - `mem_ready` set: return to RUN. The hold releases that same cycle.
  - Counter reaches MEM_TIMEOUT: go to ERR.
- Pending branch: `ex_branch_taken` is sampled in the cycle MEM_WAIT is entered and latched into `br_pend`. That cycle's flush is deferred. On the exit cycle to RUN, the flushes are asserted and `br_pend` clears.
- ERR: pipeline frozen (pc_write=0, ifid_write=0, pipe_hold=1). mem_err=1. Only `rst` leaves ERR.
- Priority: ERR > MEM_WAIT > branch > load-use.

## Timing
- While `rst` is high, and in the cycle after it falls (state RUN, no hazard):
  - During `rst`: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0, mem_err=0, counters=0, br_pend=0.
  - After `rst`: pc_write=1, ifid_write=1, flushes=0.
- Stall, flush and write-enable outputs are combinational from state plus inputs; zero-cycle latency.
- `mem_err` and the counters are registered; they update one cycle after the event.
- Load-use penalty is 1 cycle; taken-branch penalty is 2 squashed instructions.
- Wait counter width is clog2(MEM_TIMEOUT+1). It saturates and never wraps.
- `rst` asserted mid-MEM_WAIT or in ERR returns to RUN on the next edge and clears `br_pend`.

## Configuration
- HAZARD_PERF_EN defined:
  - `stall_cnt` increments on every cycle with pc_write=0 outside reset.
  - `flush_cnt` increments on every cycle with ifid_flush=1 outside reset.
  - Both are 16-bit, saturate at 0xFFFF, and clear on `rst`.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2)
  - REG_W
  - the zero register constant
- One sub-module `hazard_perf_cnt`: the saturating 16-bit counter, instantiated twice under HAZARD_PERF_EN.

## Test plan
- Load-use: idex_mem_read=1, idex_rt=5, ifid_rs=5 → exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1. Next cycle back to all-run.
- Load to $0: idex_rt=0, ifid_rs=0 → no stall.
- Branch with load-use: ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → pipe_hold=1 for 3 cycles, released on the ready cycle. A branch taken on entry produces its flush on the exit cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → state ERR after 4 wait cycles and mem_err=1 the next cycle. rst=1 returns to RUN with mem_err=0.
- Counters (HAZARD_PERF_EN): 2 load-use stalls plus 1 branch → stall_cnt=2, flush_cnt=1. Forcing 70000 stall cycles → stall_cnt=0xFFFF.
